// File: rtl/rv32ima_pkg.sv
// Shared types for the integer register file write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32ima_pkg;

   localparam int REG_W  = 5;
   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   // One queued writeback: destination register and result word.
   typedef struct packed {
      regbits_t rd;
      word_t    data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO of writeback requests with a per-entry rd view.
// Latency: push visible at head/count the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; no push-through.
module wb_fifo
   import rv32ima_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    push,
   input  wb_req_t                 push_dat,
   input  logic                    pop,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output wb_req_t                 head,
   output logic [DEPTH-1:0]        ent_vld,
   output regbits_t [DEPTH-1:0]    ent_rd
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   wb_req_t       mem_q [DEPTH];
   wb_req_t       mem_d [DEPTH];
   logic          push_ok;
   logic          pop_ok;
   logic [AW-1:0] off;

   // Status derived purely from registered pointers.
   always_comb begin
      empty = (wptr_q == rptr_q);
      full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      count = wptr_q - rptr_q;
      head  = mem_q[rptr_q[AW-1:0]];
   end

   // Next pointer and storage state; a full FIFO never accepts, even when popping.
   always_comb begin
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      mem_d   = mem_q;
      if (push_ok) begin
         mem_d[wptr_q[AW-1:0]] = push_dat;
         wptr_d                = wptr_q + PTR_ONE;
      end
      if (pop_ok) begin
         rptr_d = rptr_q + PTR_ONE;
      end
   end

   // Slot i is occupied when its distance from the read pointer is below count.
   always_comb begin
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = AW'(i) - rptr_q[AW-1:0];
         ent_vld[i] = ({1'b0, off} < count);
         ent_rd[i]  = mem_q[i].rd;
      end
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Entry storage; contents are don't-care until the pointers cover them.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges pipeline (src0) and long-latency (src1, FIFO-buffered) results onto one RF write port.
// Latency: src0 accept -> wen next cycle; src1 push -> pop next edge at earliest -> wen after that.
// Backpressure: src1_ready = !full; src0_ready drops for one cycle once the FIFO head starved STARVE_MAX cycles.
module rf_wb_arbiter
   import rv32ima_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    src0_valid,
   output logic                    src0_ready,
   input  logic [REG_W-1:0]        src0_rd,
   input  logic [WORD_W-1:0]       src0_data,
   input  logic                    src1_valid,
   output logic                    src1_ready,
   input  logic [REG_W-1:0]        src1_rd,
   input  logic [WORD_W-1:0]       src1_data,
   output logic                    wen,
   output logic [REG_W-1:0]        wsel,
   output logic [WORD_W-1:0]       wdat,
   output logic [2**REG_W-1:0]     busy,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   logic                 wen_q, wen_d;
   logic [REG_W-1:0]     wsel_q, wsel_d;
   logic [WORD_W-1:0]    wdat_q, wdat_d;
   logic [SW-1:0]        starve_q, starve_d;

   logic                 hold;
   logic                 src0_xfer;
   logic                 push;
   logic                 pop;
   wb_req_t              push_dat;
   logic                 fifo_full;
   logic                 fifo_empty;
   wb_req_t              head;
   logic [DEPTH-1:0]     ent_vld;
   regbits_t [DEPTH-1:0] ent_rd;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .nrst     (nrst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .head     (head),
      .ent_vld  (ent_vld),
      .ent_rd   (ent_rd)
   );

   // Handshakes and grant: src0 wins unless held off; otherwise the FIFO head drains.
   always_comb begin
      hold       = (starve_q == STARVE_LIM);
      src0_ready = !hold;
      src0_xfer  = src0_valid && !hold;
      src1_ready = !fifo_full;
      push       = src1_valid && !fifo_full;
      push_dat   = '{rd: src1_rd, data: src1_data};
      pop        = !src0_xfer && !fifo_empty;
   end

   // Next output register values; x0 writes are consumed but never raise wen.
   always_comb begin
      wen_d  = 1'b0;
      wsel_d = wsel_q;
      wdat_d = wdat_q;
      if (src0_xfer) begin
         wen_d  = (src0_rd != '0);
         wsel_d = src0_rd;
         wdat_d = src0_data;
      end else if (pop) begin
         wen_d  = (head.rd != '0);
         wsel_d = head.rd;
         wdat_d = head.data;
      end
   end

   // Starvation counter: counts src0 wins over a waiting head, clears on pop or empty.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (src0_xfer) begin
         starve_d = starve_q + STARVE_ONE;
      end
   end

   // Pending-write mask from occupied FIFO slots; x0 is never reported busy.
   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) begin
            busy[ent_rd[i]] = 1'b1;
         end
      end
      busy[0] = 1'b0;
   end

   // Output and counter registers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wen_q    <= 1'b0;
         wsel_q   <= '0;
         wdat_q   <= '0;
         starve_q <= '0;
      end else begin
         wen_q    <= wen_d;
         wsel_q   <= wsel_d;
         wdat_q   <= wdat_d;
         starve_q <= starve_d;
      end
   end

   assign wen  = wen_q;
   assign wsel = wsel_q;
   assign wdat = wdat_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (DEPTH=4, STARVE_MAX=8).
// Latency: inputs driven 1ns after each rising edge, outputs checked at the same point.
// Backpressure: exercised via the starvation hold-off and a full FIFO.
module tb_rf_wb_arbiter;
   import rv32ima_pkg::*;

   localparam int DEPTH = 4;
   localparam int SM    = 8;

   logic              clk;
   logic              nrst;
   logic              src0_valid;
   logic              src0_ready;
   logic [REG_W-1:0]  src0_rd;
   logic [WORD_W-1:0] src0_data;
   logic              src1_valid;
   logic              src1_ready;
   logic [REG_W-1:0]  src1_rd;
   logic [WORD_W-1:0] src1_data;
   logic              wen;
   logic [REG_W-1:0]  wsel;
   logic [WORD_W-1:0] wdat;
   logic [31:0]       busy;
   logic [2:0]        fifo_count;

   int checks = 0;
   int errors = 0;

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .src0_valid (src0_valid),
      .src0_ready (src0_ready),
      .src0_rd    (src0_rd),
      .src0_data  (src0_data),
      .src1_valid (src1_valid),
      .src1_ready (src1_ready),
      .src1_rd    (src1_rd),
      .src1_data  (src1_data),
      .wen        (wen),
      .wsel       (wsel),
      .wdat       (wdat),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      nrst = 1'b0; src0_valid = 1'b1; src0_rd = 5'd3; src0_data = 32'h1111;
      src1_valid = 1'b1; src1_rd = 5'd9; src1_data = 32'h9999;
      tick; tick;
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0h exp 0", wen); end
      checks++; if (wsel !== 5'd0) begin errors++; $display("FAIL reset_wsel: got %0h exp 0", wsel); end
      checks++; if (wdat !== 32'h0) begin errors++; $display("FAIL reset_wdat: got %0h exp 0", wdat); end
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %0h exp 0", busy); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
      checks++; if (src1_ready !== 1'b1) begin errors++; $display("FAIL reset_src1_ready: got %0h exp 1", src1_ready); end
      nrst = 1'b1; src1_valid = 1'b0; src0_rd = 5'd5; src0_data = 32'hDEADBEEF;
      tick;
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL first_wen: got %0h exp 1", wen); end
      checks++; if (wsel !== 5'd5) begin errors++; $display("FAIL first_wsel: got %0d exp 5", wsel); end
      checks++; if (wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL first_wdat: got %0h exp deadbeef", wdat); end
      src0_valid = 1'b0;
      tick;
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL idle_wen: got %0h exp 0", wen); end
      checks++; if (wsel !== 5'd5) begin errors++; $display("FAIL idle_wsel_hold: got %0d exp 5", wsel); end
      checks++; if (wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_wdat_hold: got %0h exp deadbeef", wdat); end
   endtask

   task automatic test_priority;
      src0_valid = 1'b1; src0_rd = 5'd1; src0_data = 32'h100;
      src1_valid = 1'b1; src1_rd = 5'd7; src1_data = 32'h77;
      tick;
      src1_valid = 1'b0;
      checks++; if (wsel !== 5'd1) begin errors++; $display("FAIL prio_first_wsel: got %0d exp 1", wsel); end
      checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL prio_busy_set: got %0h exp 1", busy[7]); end
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL prio_count: got %0d exp 1", fifo_count); end
      for (int i = 0; i < SM; i++) begin
         checks++; if (src0_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_%0d: got %0h exp 1", i, src0_ready); end
         src0_rd = 5'(i + 2); src0_data = 32'h200 + 32'(i);
         tick;
         checks++; if (wsel !== 5'(i + 2) || wen !== 1'b1) begin errors++; $display("FAIL prio_grant_%0d: got wsel %0d wen %0h exp wsel %0d wen 1", i, wsel, wen, i + 2); end
      end
      checks++; if (src0_ready !== 1'b0) begin errors++; $display("FAIL prio_hold: got %0h exp 0", src0_ready); end
      checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL prio_busy_wait: got %0h exp 1", busy[7]); end
      tick;
      checks++; if (wsel !== 5'd7) begin errors++; $display("FAIL prio_pop_wsel: got %0d exp 7", wsel); end
      checks++; if (wdat !== 32'h77) begin errors++; $display("FAIL prio_pop_wdat: got %0h exp 77", wdat); end
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL prio_pop_wen: got %0h exp 1", wen); end
      checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL prio_busy_clr: got %0h exp 0", busy[7]); end
      checks++; if (src0_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_back: got %0h exp 1", src0_ready); end
      src0_valid = 1'b0;
      tick;
   endtask

   task automatic test_full;
      src0_valid = 1'b1; src0_rd = 5'd20; src0_data = 32'h2020;
      for (int i = 0; i < DEPTH; i++) begin
         src1_valid = 1'b1; src1_rd = 5'(10 + i); src1_data = 32'hA0 + 32'(i);
         tick;
      end
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d exp 4", fifo_count); end
      checks++; if (src1_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h exp 0", src1_ready); end
      checks++; if (busy !== 32'h0000_3C00) begin errors++; $display("FAIL full_busy: got %0h exp 3c00", busy); end
      src1_rd = 5'd14; src1_data = 32'hA4;
      tick;
      checks++; if (fifo_count !== 3'd4 || src1_ready !== 1'b0) begin errors++; $display("FAIL full_held: got count %0d ready %0h exp 4 0", fifo_count, src1_ready); end
      checks++; if (wsel !== 5'd20) begin errors++; $display("FAIL full_src0_wins: got %0d exp 20", wsel); end
      src0_valid = 1'b0;
      tick;
      checks++; if (wsel !== 5'd10 || wdat !== 32'hA0) begin errors++; $display("FAIL drain_0: got %0d/%0h exp 10/a0", wsel, wdat); end
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL no_push_through: got %0d exp 3", fifo_count); end
      tick;
      src1_valid = 1'b0;
      checks++; if (wsel !== 5'd11 || wdat !== 32'hA1) begin errors++; $display("FAIL drain_1: got %0d/%0h exp 11/a1", wsel, wdat); end
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL fifth_pushed: got %0d exp 3", fifo_count); end
      for (int i = 2; i < 5; i++) begin
         tick;
         checks++; if (wsel !== 5'(10 + i) || wdat !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL drain_%0d: got %0d/%0h exp %0d/%0h", i, wsel, wdat, 10 + i, 32'hA0 + i); end
      end
      checks++; if (fifo_count !== 3'd0 || busy !== 32'h0) begin errors++; $display("FAIL full_drained: got count %0d busy %0h exp 0 0", fifo_count, busy); end
   endtask

   task automatic test_x0;
      src0_valid = 1'b1; src0_rd = 5'd0; src0_data = 32'h1234;
      src1_valid = 1'b1; src1_rd = 5'd0; src1_data = 32'h55;
      tick;
      src0_valid = 1'b0; src1_valid = 1'b0;
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL x0_src0_wen: got %0h exp 0", wen); end
      checks++; if (wsel !== 5'd0 || wdat !== 32'h1234) begin errors++; $display("FAIL x0_src0_load: got %0d/%0h exp 0/1234", wsel, wdat); end
      checks++; if (fifo_count !== 3'd1 || busy !== 32'h0) begin errors++; $display("FAIL x0_queued: got count %0d busy %0h exp 1 0", fifo_count, busy); end
      tick;
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL x0_src1_wen: got %0h exp 0", wen); end
      checks++; if (fifo_count !== 3'd0 || wdat !== 32'h55) begin errors++; $display("FAIL x0_popped: got count %0d wdat %0h exp 0 55", fifo_count, wdat); end
   endtask

   task automatic test_back_to_back;
      src0_valid = 1'b1; src0_rd = 5'd2; src0_data = 32'h22;
      src1_valid = 1'b1; src1_rd = 5'd3; src1_data = 32'h33;
      tick;
      src1_rd = 5'd4; src1_data = 32'h44;
      tick;
      checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_setup: got %0d exp 2", fifo_count); end
      src0_valid = 1'b0; src1_rd = 5'd6; src1_data = 32'h66;
      tick;
      src1_valid = 1'b0;
      checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_count: got %0d exp 2", fifo_count); end
      checks++; if (wsel !== 5'd3 || wdat !== 32'h33) begin errors++; $display("FAIL pp_head: got %0d/%0h exp 3/33", wsel, wdat); end
      checks++; if (busy !== 32'h0000_0050) begin errors++; $display("FAIL pp_busy: got %0h exp 50", busy); end
      tick;
      checks++; if (wsel !== 5'd4 || wdat !== 32'h44) begin errors++; $display("FAIL pp_next: got %0d/%0h exp 4/44", wsel, wdat); end
      tick;
      checks++; if (wsel !== 5'd6 || wdat !== 32'h66 || fifo_count !== 3'd0) begin errors++; $display("FAIL pp_last: got %0d/%0h/%0d exp 6/66/0", wsel, wdat, fifo_count); end
   endtask

   task automatic test_reset_mid;
      src0_valid = 1'b1; src0_rd = 5'd8; src0_data = 32'h88;
      for (int i = 0; i < 3; i++) begin
         src1_valid = 1'b1; src1_rd = 5'(15 + i); src1_data = 32'hF0 + 32'(i);
         tick;
      end
      checks++; if (fifo_count !== 3'd3 || busy !== 32'h0003_8000) begin errors++; $display("FAIL mid_setup: got count %0d busy %0h exp 3 38000", fifo_count, busy); end
      nrst = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0;
      tick;
      checks++; if (wen !== 1'b0 || fifo_count !== 3'd0 || busy !== 32'h0) begin errors++; $display("FAIL mid_reset: got wen %0h count %0d busy %0h exp 0 0 0", wen, fifo_count, busy); end
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (wen !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL mid_after_%0d: got wen %0h count %0d exp 0 0", i, wen, fifo_count); end
      end
   endtask

   initial begin
      nrst = 1'b0; src0_valid = 1'b0; src0_rd = '0; src0_data = '0;
      src1_valid = 1'b0; src1_rd = '0; src1_data = '0;
      test_reset;
      test_priority;
      test_full;
      test_x0;
      test_back_to_back;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
